// File: rtl/tug_match_ctrl.sv
// tug_match_ctrl: match sequencer for the tug-of-war game.
// The sequencer gates play, clears the field between rounds, and keeps a round score per player.
// Each score drives an active-low 7-seg digit.
// It declares the match champion once a player reaches WIN_SCORE.
// All outputs decode registered state only (Moore).
`timescale 1ns/1ps
module tug_match_ctrl #(
  parameter int WIN_SCORE   = 3,
  parameter int ARM_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic       field_reset,
  output logic       play_en,
  output logic [6:0] score1_hex,
  output logic [6:0] score2_hex,
  output logic       match_over,
  output logic [1:0] champ
);

  // The shared cycle counter must hold the larger of the two load values.
  localparam int CNT_MAX = (ARM_CYCLES > HOLD_CYCLES) ? ARM_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ARM_LOAD  = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]       WIN       = 3'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PLAY,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       score1_reg, score1_next;
  logic [2:0]       score2_reg, score2_next;
  logic [2:0]       score1_inc, score2_inc;

  // Active-low 7-seg glyphs for digits 0..7 (segment g is the MSB).
  function automatic logic [6:0] seg7(input logic [2:0] digit);
    logic [6:0] seg;
    case (digit)
      3'd0:    seg = 7'b1000000;
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      3'd5:    seg = 7'b0010010;
      3'd6:    seg = 7'b0000010;
      default: seg = 7'b1111000;
    endcase
    return seg;
  endfunction

  // State, counter and score registers; reset aborts everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      score1_reg <= 3'd0;
      score2_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      score1_reg <= score1_next;
      score2_reg <= score2_next;
    end
  end

  assign score1_inc = score1_reg + 3'd1;
  assign score2_inc = score2_reg + 3'd1;

  // Next-state logic: round sequencing, scoring and match restart.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    score1_next = score1_reg;
    score2_next = score2_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_ARM;
          cnt_next   = ARM_LOAD;
        end
      end
      S_ARM: begin
        if (cnt_reg == '0) begin
          state_next = S_PLAY;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_PLAY: begin
        if (p1_win && !p2_win) begin
          score1_next = score1_inc;
          if (score1_inc == WIN) begin
            state_next = S_DONE;
          end else begin
            state_next = S_HOLD;
            cnt_next   = HOLD_LOAD;
          end
        end else if (p2_win && !p1_win) begin
          score2_next = score2_inc;
          if (score2_inc == WIN) begin
            state_next = S_DONE;
          end else begin
            state_next = S_HOLD;
            cnt_next   = HOLD_LOAD;
          end
        end else if (p1_win && p2_win) begin
          // Drawn round: no score, but the round still ends.
          state_next = S_HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt_reg == '0) begin
          state_next = S_ARM;
          cnt_next   = ARM_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          score1_next = 3'd0;
          score2_next = 3'd0;
          state_next  = S_ARM;
          cnt_next    = ARM_LOAD;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Control outputs decoded from the current state and scores.
  always_comb begin
    field_reset = 1'b0;
    play_en     = 1'b0;
    match_over  = 1'b0;
    champ       = 2'b00;
    case (state_reg)
      S_IDLE, S_ARM: field_reset = 1'b1;
      S_PLAY:        play_en     = 1'b1;
      S_DONE: begin
        match_over = 1'b1;
        champ      = (score1_reg == WIN) ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

  // One identical digit decoder per player.
  logic [2:0] score_arr [2];
  logic [6:0] hex_arr   [2];

  assign score_arr[0] = score1_reg;
  assign score_arr[1] = score2_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hex
      assign hex_arr[gi] = seg7(score_arr[gi]);
    end
  endgenerate

  assign score1_hex = hex_arr[0];
  assign score2_hex = hex_arr[1];

endmodule
